// File: rtl/gamecontrol_seq_if.sv
// Game controller bus: everything the sequence-memory controller exchanges with
// its surroundings except clock and reset.
//
// Signals
//   morse_number  digit offered by the morse source
//   game_start    level; starts or restarts a game
//   level         requested sequence length, sampled at round start
//   load          one-cycle strobe qualifying user_input
//   user_input    digit entered by the player
//   timeout       global game time expired
//   reconfig      one-cycle request to reconfigure the digit source
//   enable        a game is running (drives the global timer)
//   number        digit currently displayed, 0 when none
//   correct       outcome of the last completed round
//   round_done    one-cycle pulse when a round is scored
//   game_over     game has ended
//   score_ones    BCD score units
//   score_tens    BCD score tens
//   state_dbg     controller state, for observation only
//
// Modports: slave is the controller, master is its environment.
//
// Handshake: there is no ready/valid pair. load is a single-cycle strobe and
// user_input is meaningful only in a cycle where load=1; the controller takes
// it in the COLLECT state and silently drops it anywhere else. Every output
// is a level or a one-cycle pulse and needs no acknowledge.
interface gamecontrol_seq_if #(
  parameter int DW = 4,
  parameter int LW = 3
);
  logic [DW-1:0] morse_number;
  logic          game_start;
  logic [LW-1:0] level;
  logic          load;
  logic [DW-1:0] user_input;
  logic          timeout;
  logic          reconfig;
  logic          enable;
  logic [DW-1:0] number;
  logic          correct;
  logic          round_done;
  logic          game_over;
  logic [3:0]    score_ones;
  logic [3:0]    score_tens;
  logic [2:0]    state_dbg;

  modport slave (
    input  morse_number, game_start, level, load, user_input, timeout,
    output reconfig, enable, number, correct, round_done, game_over,
           score_ones, score_tens, state_dbg
  );

  modport master (
    output morse_number, game_start, level, load, user_input, timeout,
    input  reconfig, enable, number, correct, round_done, game_over,
           score_ones, score_tens, state_dbg
  );
endinterface

// File: rtl/gamecontrol_seq.sv
// Sequence-memory game controller. Each round displays len digits (taken from
// the morse source, one every SHOW_CYCLES cycles), then collects len digits
// from the player and scores the round into a saturating two-digit BCD count.
//
// Ports
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   gamecontrol_seq_if.slave (all game inputs and outputs)
module gamecontrol_seq #(
  parameter int DW          = 4,
  parameter int MAX_LEN     = 4,
  parameter int LW          = 3,
  parameter int SHOW_CYCLES = 250000000
) (
  input  logic             clk,
  input  logic             rst,
  gamecontrol_seq_if.slave bus
);

  localparam int LENW = $clog2(MAX_LEN + 1);
  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW   = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RECONFIG   = 3'd1,
    S_WAIT_START = 3'd2,
    S_SHOW       = 3'd3,
    S_COLLECT    = 3'd4,
    S_DECISION   = 3'd5,
    S_GAMEOVER   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [LENW-1:0] len_q;
  logic [LENW-1:0] idx_q;
  logic [TW-1:0]   timer_q;
  logic            match_q;
  logic [DW-1:0]   dig_buf [MAX_LEN];
  logic [DW-1:0]   number_q;
  logic            correct_q;
  logic [3:0]      ones_q;
  logic [3:0]      tens_q;

  logic reconfig_c, enable_c, round_done_c, game_over_c;
  logic in_round, abort, show_done, slot_first, slot_last, collect_last;

  // Out-of-range lengths are folded into 1..MAX_LEN.
  function automatic logic [LENW-1:0] clamp_len(input logic [LW-1:0] lvl);
    if (lvl == '0)                return LENW'(1);
    else if (int'(lvl) > MAX_LEN) return LENW'(MAX_LEN);
    else                          return LENW'(lvl);
  endfunction

  assign in_round     = (state_q == S_SHOW) || (state_q == S_COLLECT) ||
                        (state_q == S_DECISION);
  assign abort        = in_round && bus.timeout;
  // idx == len in SHOW is one trailing cycle after the last slot; it lets the
  // final digit stay on number for the full SHOW_CYCLES like the others.
  assign show_done    = (idx_q == len_q);
  assign slot_first   = (timer_q == '0);
  assign slot_last    = (timer_q == TW'(SHOW_CYCLES - 1));
  assign collect_last = bus.load && ((idx_q + LENW'(1)) == len_q);

  always_comb begin
    state_d      = state_q;
    reconfig_c   = 1'b0;
    enable_c     = 1'b0;
    round_done_c = 1'b0;
    game_over_c  = 1'b0;
    case (state_q)
      S_IDLE:       state_d = S_RECONFIG;
      S_RECONFIG: begin
        reconfig_c = 1'b1;
        state_d    = S_WAIT_START;
      end
      S_WAIT_START: if (bus.game_start) state_d = S_SHOW;
      S_SHOW: begin
        enable_c = 1'b1;
        if (show_done) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        enable_c = 1'b1;
        if (collect_last) state_d = S_DECISION;
      end
      S_DECISION: begin
        enable_c     = 1'b1;
        round_done_c = 1'b1;
        state_d      = S_SHOW;
      end
      S_GAMEOVER: begin
        game_over_c = 1'b1;
        if (bus.game_start) state_d = S_RECONFIG;
      end
      default:      state_d = S_IDLE;
    endcase
    if (abort) state_d = S_GAMEOVER;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      match_q   <= 1'b0;
      number_q  <= '0;
      correct_q <= 1'b0;
      ones_q    <= '0;
      tens_q    <= '0;
      for (int i = 0; i < MAX_LEN; i++) dig_buf[i] <= '0;
    end else begin
      state_q <= state_d;
      if (abort) begin
        // Timeout freezes score and correct; only the display is blanked.
        number_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            idx_q   <= '0;
            timer_q <= '0;
            match_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) dig_buf[i] <= '0;
          end
          S_WAIT_START: begin
            if (bus.game_start) begin
              len_q     <= clamp_len(bus.level);
              idx_q     <= '0;
              timer_q   <= '0;
              number_q  <= '0;
              correct_q <= 1'b0;
              ones_q    <= '0;
              tens_q    <= '0;
            end
          end
          S_SHOW: begin
            if (show_done) begin
              number_q <= '0;
              idx_q    <= '0;
              timer_q  <= '0;
              match_q  <= 1'b1;
            end else begin
              if (slot_first) begin
                dig_buf[idx_q[IW-1:0]] <= bus.morse_number;
                number_q               <= bus.morse_number;
              end
              if (slot_last) begin
                timer_q <= '0;
                idx_q   <= idx_q + LENW'(1);
              end else begin
                timer_q <= timer_q + TW'(1);
              end
            end
          end
          S_COLLECT: begin
            if (bus.load) begin
              if (bus.user_input != dig_buf[idx_q[IW-1:0]]) match_q <= 1'b0;
              idx_q <= idx_q + LENW'(1);
            end
          end
          S_DECISION: begin
            correct_q <= match_q;
            if (match_q) begin
              if (ones_q == 4'd9) begin
                if (tens_q != 4'd9) begin
                  ones_q <= 4'd0;
                  tens_q <= tens_q + 4'd1;
                end
              end else begin
                ones_q <= ones_q + 4'd1;
              end
            end
            len_q   <= clamp_len(bus.level);
            idx_q   <= '0;
            timer_q <= '0;
          end
          S_GAMEOVER: number_q <= '0;
          default: ;
        endcase
      end
    end
  end

  assign bus.reconfig   = reconfig_c;
  assign bus.enable     = enable_c;
  assign bus.round_done = round_done_c;
  assign bus.game_over  = game_over_c;
  assign bus.number     = number_q;
  assign bus.correct    = correct_q;
  assign bus.score_ones = ones_q;
  assign bus.score_tens = tens_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_gamecontrol_seq.sv
// Bench for gamecontrol_seq: random rounds driven against a score/sequence
// model; a monitor checks displayed digits and round results from queues.
module tb_gamecontrol_seq;
  localparam int DW          = 4;
  localparam int LW          = 3;
  localparam int MAX_LEN     = 4;
  localparam int SHOW_CYCLES = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gamecontrol_seq_if #(.DW(DW), .LW(LW)) bus();

  gamecontrol_seq #(
    .DW(DW), .MAX_LEN(MAX_LEN), .LW(LW), .SHOW_CYCLES(SHOW_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [DW-1:0] show_q[$];   // one entry per cycle a digit must be on number
  logic [8:0]    res_q[$];    // {correct, tens, ones} after each round_done
  int m_score;
  bit m_correct;
  int cur_lvl;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_len(input int lvl);
    if (lvl == 0) return 1;
    if (lvl > MAX_LEN) return MAX_LEN;
    return lvl;
  endfunction

  // ---------------- monitor ----------------
  logic [8:0] pend_exp;
  bit pend = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("round_result", int'({bus.correct, bus.score_tens, bus.score_ones}),
              int'(pend_exp));
          pend = 0;
        end
        if (bus.number != '0) begin
          if (show_q.size() == 0) chk("number_unexpected", int'(bus.number), 0);
          else chk("number", int'(bus.number), int'(show_q.pop_front()));
        end
        if (bus.round_done) begin
          if (res_q.size() == 0) chk("round_done_unexpected", int'(bus.round_done), 0);
          else begin
            pend_exp = res_q.pop_front();
            pend = 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reconfig"},   int'(bus.reconfig), 0);
    chk({tag, "_enable"},     int'(bus.enable), 0);
    chk({tag, "_number"},     int'(bus.number), 0);
    chk({tag, "_correct"},    int'(bus.correct), 0);
    chk({tag, "_round_done"}, int'(bus.round_done), 0);
    chk({tag, "_game_over"},  int'(bus.game_over), 0);
    chk({tag, "_ones"},       int'(bus.score_ones), 0);
    chk({tag, "_tens"},       int'(bus.score_tens), 0);
  endtask

  // Holds reset through one more edge, releases it, and checks that reconfig
  // pulses in the second cycle only.
  task automatic release_checks();
    step();
    rst = 1'b1;
    at_neg(); chk("rel_c1_reconfig", int'(bus.reconfig), 0);
    step();
    at_neg(); chk("rel_c2_reconfig", int'(bus.reconfig), 1);
    step();
    at_neg(); chk("rel_c3_reconfig", int'(bus.reconfig), 0);
    chk("rel_c3_enable", int'(bus.enable), 0);
  endtask

  task automatic start_game(input int lvl);
    bus.level      = LW'(lvl);
    bus.game_start = 1'b1;
    step();
    bus.game_start = 1'b0;
    m_score   = 0;
    m_correct = 0;
    cur_lvl   = lvl;
    at_neg();
    chk("start_ones", int'(bus.score_ones), 0);
    chk("start_tens", int'(bus.score_tens), 0);
    chk("start_correct", int'(bus.correct), 0);
    chk("start_enable", int'(bus.enable), 1);
  endtask

  // One round. to_at: -1 none, 0..n-1 timeout before load k, n timeout in
  // the scoring cycle. fixed uses digits 3,7 (and 5 as the wrong entry).
  task automatic run_round(input int lvl_next, input bit win, input int to_at,
                           input bit fixed);
    int n;
    int bad;
    bit ok;
    logic [DW-1:0] d[MAX_LEN];
    logic [DW-1:0] u[MAX_LEN];
    n = clamp_len(cur_lvl);
    for (int k = 0; k < n; k++)
      d[k] = fixed ? ((k == 0) ? DW'(3) : DW'(7)) : DW'($urandom_range(1, 15));
    bad = win ? -1 : int'($urandom_range(0, n - 1));
    if (fixed && !win) bad = n - 1;
    for (int k = 0; k < n; k++) begin
      u[k] = d[k];
      if (k == bad) u[k] = fixed ? DW'(5) : (d[k] ^ DW'($urandom_range(1, 15)));
    end
    for (int k = 0; k < n; k++)
      repeat (SHOW_CYCLES) show_q.push_back(d[k]);
    // display phase, with one stray load that must be ignored
    for (int k = 0; k < n; k++) begin
      bus.morse_number = d[k];
      for (int t = 0; t < SHOW_CYCLES; t++) begin
        bus.load       = (k == 0 && t == 1);
        bus.user_input = DW'($urandom);
        step();
      end
    end
    bus.load         = 1'b0;
    bus.morse_number = DW'($urandom);
    step();
    bus.level = LW'(lvl_next);
    for (int k = 0; k < n; k++) begin
      if (to_at == k) begin
        bus.timeout = 1'b1;
        step();
        bus.timeout = 1'b0;
        cur_lvl = lvl_next;
        return;
      end
      if ($urandom_range(0, 1) == 1) step();
      bus.load       = 1'b1;
      bus.user_input = u[k];
      step();
      bus.load = 1'b0;
    end
    ok = 1;
    for (int k = 0; k < n; k++) if (u[k] != d[k]) ok = 0;
    if (to_at == n) begin
      bus.timeout = 1'b1;
    end else begin
      m_correct = ok;
      if (ok && m_score < 99) m_score++;
    end
    res_q.push_back({m_correct, 4'(m_score / 10), 4'(m_score % 10)});
    step();
    bus.timeout = 1'b0;
    cur_lvl = lvl_next;
  endtask

  task automatic gameover_checks(input string tag);
    at_neg();
    chk({tag, "_game_over"}, int'(bus.game_over), 1);
    chk({tag, "_enable"},    int'(bus.enable), 0);
    chk({tag, "_number"},    int'(bus.number), 0);
    chk({tag, "_ones"},      int'(bus.score_ones), m_score % 10);
    chk({tag, "_tens"},      int'(bus.score_tens), m_score / 10);
    chk({tag, "_correct"},   int'(bus.correct), int'(m_correct));
  endtask

  task automatic restart(input string tag);
    bus.game_start = 1'b1;
    step();
    bus.game_start = 1'b0;
    at_neg();
    chk({tag, "_reconfig"}, int'(bus.reconfig), 1);
    chk({tag, "_held_ones"}, int'(bus.score_ones), m_score % 10);
    chk({tag, "_held_tens"}, int'(bus.score_tens), m_score / 10);
    step();
    at_neg();
    chk({tag, "_wait_game_over"}, int'(bus.game_over), 0);
    chk({tag, "_wait_ones"}, int'(bus.score_ones), m_score % 10);
    chk({tag, "_wait_tens"}, int'(bus.score_tens), m_score / 10);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.morse_number = '0;
    bus.game_start   = 1'b0;
    bus.level        = '0;
    bus.load         = 1'b0;
    bus.user_input   = '0;
    bus.timeout      = 1'b0;
    m_score   = 0;
    m_correct = 0;
    cur_lvl   = 0;

    repeat (3) step();
    at_neg();
    chk_all_zero("reset");
    release_checks();

    // Game A: directed rounds, random rounds, level clamping, decision timeout
    start_game(2);
    run_round(2, 1, -1, 1);
    run_round($urandom_range(0, 7), 0, -1, 1);
    for (int r = 0; r < 6; r++)
      run_round($urandom_range(0, 7), 1'($urandom_range(0, 1)), -1, 0);
    run_round(7, 1, -1, 0);
    run_round(0, 1, -1, 0);
    run_round(3, 1, -1, 0);
    run_round(2, 1, clamp_len(cur_lvl), 0);
    gameover_checks("decision_timeout");
    restart("restart_a");

    // Game B: random rounds then a timeout while collecting
    start_game($urandom_range(0, 7));
    for (int r = 0; r < 3; r++)
      run_round($urandom_range(0, 7), 1'($urandom_range(0, 1)), -1, 0);
    run_round(0, 1, int'($urandom_range(0, clamp_len(cur_lvl) - 1)), 0);
    gameover_checks("collect_timeout");
    restart("restart_b");

    // Game C: single-digit wins up past the 99 ceiling
    start_game(0);
    for (int r = 0; r < 104; r++) run_round(0, 1, -1, 0);
    at_neg();
    chk("sat_ones", int'(bus.score_ones), 9);
    chk("sat_tens", int'(bus.score_tens), 9);

    // Asynchronous reset in the middle of a display slot
    bus.morse_number = DW'(5);
    show_q.push_back(DW'(5));
    step();
    chk("pre_rst_number", int'(bus.number), 5);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    show_q.delete();
    release_checks();

    step();
    chk("leftover_show", show_q.size(), 0);
    chk("leftover_results", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
